// File: rtl/sync_mem_bank_if.sv
// Request/response bundle for sync_mem_bank: one read port, one byte-enabled write port,
// plus the busy indication consumed by the pipeline stall logic.
interface sync_mem_bank_if #(
    parameter int WIDTH = 32
);
    logic               rd_req;
    logic [31:0]        rd_addr;
    logic               wr_req;
    logic [31:0]        wr_addr;
    logic [WIDTH-1:0]   wr_data;
    logic [WIDTH/8-1:0] wr_be;
    logic               rd_valid;
    logic [WIDTH-1:0]   rd_data;
    logic               rd_err;
    logic               wr_err;
    logic               busy;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        input  rd_valid, rd_data, rd_err, wr_err, busy
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        output rd_valid, rd_data, rd_err, wr_err, busy
    );
endinterface

// File: rtl/sync_mem_bank.sv
// Synchronous word-addressed memory bank with byte-enable writes, write-first read bypass,
// 1- or 2-cycle pipelined reads, registered error flags and an optional post-reset clear.
module sync_mem_bank #(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 1024,
    parameter int RD_LATENCY     = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic            clk,
    input  logic            rst,
    sync_mem_bank_if.slave  bus
);
    localparam int          NB         = WIDTH / 8;
    localparam int          ADDR_LSB   = $clog2(NB);
    localparam int          IDX_W      = $clog2(DEPTH);
    localparam logic [31:0] ALIGN_MASK = 32'(NB - 1);
    localparam logic [31:0] DEPTH32    = 32'(DEPTH);

    generate
        if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_latency
            $fatal(1, "sync_mem_bank: RD_LATENCY must be 1 or 2");
        end
        if (WIDTH % 8 != 0 || WIDTH < 8) begin : g_bad_width
            $fatal(1, "sync_mem_bank: WIDTH must be a non-zero multiple of 8");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $fatal(1, "sync_mem_bank: DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_clr_ptr;
    logic              r_busy;
    logic              r_wr_err;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic [RD_LATENCY:1]             r_vld_pipe;
    logic [RD_LATENCY:1]             r_err_pipe;
    logic [RD_LATENCY:1][WIDTH-1:0]  r_dat_pipe;

    logic              w_ready;
    logic [31:0]       w_rd_widx, w_wr_widx;
    logic [IDX_W-1:0]  w_rd_idx, w_wr_idx;
    logic              w_rd_bad, w_wr_bad;
    logic              w_rd_acc, w_wr_acc, w_wr_hit;
    logic [WIDTH-1:0]  w_wr_mask, w_rd_word, w_rd_data;

    assign w_ready   = (r_state == S_READY);

    // Range check uses the full 32-bit word index so high addresses never alias into the array.
    assign w_rd_widx = bus.rd_addr >> ADDR_LSB;
    assign w_wr_widx = bus.wr_addr >> ADDR_LSB;
    assign w_rd_idx  = w_rd_widx[IDX_W-1:0];
    assign w_wr_idx  = w_wr_widx[IDX_W-1:0];
    assign w_rd_bad  = (|(bus.rd_addr & ALIGN_MASK)) || (w_rd_widx >= DEPTH32);
    assign w_wr_bad  = (|(bus.wr_addr & ALIGN_MASK)) || (w_wr_widx >= DEPTH32);
    assign w_rd_acc  = w_ready && bus.rd_req;
    assign w_wr_acc  = w_ready && bus.wr_req && !w_wr_bad;

    always_comb begin
        w_wr_mask = '0;
        for (int b = 0; b < NB; b++) w_wr_mask[8*b +: 8] = {8{bus.wr_be[b]}};
    end

    // Write-first: a same-word write in the request cycle is merged into the returned word.
    assign w_rd_word = r_mem[w_rd_idx];
    assign w_wr_hit  = w_wr_acc && (w_wr_idx == w_rd_idx);
    assign w_rd_data = w_rd_bad ? '0 :
                       w_wr_hit ? ((bus.wr_data & w_wr_mask) | (w_rd_word & ~w_wr_mask)) :
                                  w_rd_word;

    // Array writes live under the reset branch so a write coincident with rst is dropped;
    // the array itself is never initialised by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
            r_busy    <= (CLEAR_ON_RESET != 0);
            r_clr_ptr <= '0;
            r_wr_err  <= 1'b0;
        end else begin
            r_wr_err <= w_ready && bus.wr_req && w_wr_bad;
            case (r_state)
                S_CLEAR: begin
                    r_mem[r_clr_ptr] <= '0;
                    r_clr_ptr        <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == IDX_W'(DEPTH - 1)) begin
                        r_state <= S_READY;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    if (w_wr_acc)
                        for (int b = 0; b < NB; b++)
                            if (bus.wr_be[b]) r_mem[w_wr_idx][8*b +: 8] <= bus.wr_data[8*b +: 8];
                end
            endcase
        end
    end

    // Stage 1 samples the array at the request edge; stage 2 (if present) is a pure output
    // register. Data only moves with a valid so rd_data holds between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_err_pipe <= '0;
            r_dat_pipe <= '0;
        end else begin
            r_vld_pipe[1] <= w_rd_acc;
            r_err_pipe[1] <= w_rd_acc && w_rd_bad;
            if (w_rd_acc) r_dat_pipe[1] <= w_rd_data;
            for (int s = 2; s <= RD_LATENCY; s++) begin
                r_vld_pipe[s] <= r_vld_pipe[s-1];
                r_err_pipe[s] <= r_vld_pipe[s-1] && r_err_pipe[s-1];
                if (r_vld_pipe[s-1]) r_dat_pipe[s] <= r_dat_pipe[s-1];
            end
        end
    end

    assign bus.rd_valid = r_vld_pipe[RD_LATENCY];
    assign bus.rd_err   = r_err_pipe[RD_LATENCY];
    assign bus.rd_data  = r_dat_pipe[RD_LATENCY];
    assign bus.wr_err   = r_wr_err;
    assign bus.busy     = r_busy;
endmodule
